// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES inverse-cipher datapath.
//   - size encodings (SZ_128 / SZ_192) and matching round counts
//   - width of the flattened round-key schedule
//   - FSM state constants for the iterative core
//   - inverse S-box table and GF(2^8) helpers used by InvSubBytes and
//     InvMixColumns
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [1:0] SZ_128 = 2'b00;
  localparam logic [1:0] SZ_192 = 2'b01;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;

  localparam int KSCHED_W = 1664;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; byte 0 of the column is in the MSBs.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter_if
//   Handshake/data bundle of the iterative AES inverse cipher.
//   Input side : in_valid/in_ready, in (ciphertext), key_sched, size
//   Output side: out_valid/out_ready, out (plaintext), err
//   master : the environment (key-schedule source + block consumer)
//   slave  : the decrypt core
// ---------------------------------------------------------------------------
interface aes_inv_cipher_iter_if;
  import aes_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in;
  logic [KSCHED_W-1:0] key_sched;
  logic [1:0]          size;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out;
  logic                err;

  modport master (
    output in_valid, in, key_sched, size, out_ready,
    input  in_ready, out_valid, out, err
  );

  modport slave (
    input  in_valid, in, key_sched, size, out_ready,
    output in_ready, out_valid, out, err
  );

endinterface

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
//   One combinational AES inverse round:
//     state_out = InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ rk)
//   With last=1 the InvMixColumns step is bypassed (final round).
// Ports
//   state_in  in  128  current state, byte 0 = [127:120], column-major
//   rk        in  128  round key for this round
//   last      in  1    final round select
//   state_out out 128  next state
// ---------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] ark;
  logic [127:0] mixed;
  logic [7:0]   sb;

  // Byte (r,c) lives at index r+4c. InvShiftRows rotates row r right by r,
  // so output (r,c) takes input (r,(c-r) mod 4) before the S-box lookup.
  always_comb begin
    ark   = '0;
    mixed = '0;
    sb    = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb = INV_SBOX[state_in[127-8*(r+4*((c-r+4)%4)) -: 8]];
        ark[127-8*(r+4*c) -: 8] = sb ^ rk[127-8*(r+4*c) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
    state_out = last ? ark : mixed;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter
//   Iterative AES-128/192 inverse cipher, one round per clock, one block in
//   flight. The initial AddRoundKey with rk[Nr] happens on the accepting
//   edge; each following edge applies one inverse round, so out_valid rises
//   Nr cycles after accept. Unsupported sizes answer after one cycle with
//   err=1 and out=0.
// Ports
//   clk    in  1   rising-edge clock
//   rst_n  in  1   synchronous active-low reset
//   bus    slave modport of aes_inv_cipher_iter_if
//          (in_valid/in_ready/in/key_sched/size, out_valid/out_ready/out/err)
// Parameters
//   NK_MAX number of round-key slots in key_sched (13)
// ---------------------------------------------------------------------------
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK_MAX = 13
)
(
  input  logic              clk,
  input  logic              rst_n,
  aes_inv_cipher_iter_if.slave bus
);

  // Slot NK_MAX-1 (rk[12]) is only ever needed on the accepting edge, so
  // only slots 0..NK_MAX-2 are held across the run.
  localparam int LATCH_W = 128 * (NK_MAX - 1);

  logic [1:0]         st;
  logic [3:0]         rnd;
  logic [127:0]       state_q;
  logic [LATCH_W-1:0] ks_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               err_q;
  logic [127:0]       out_q;

  logic               accept;
  logic               size_ok;
  logic [3:0]         nr_sel;
  logic [127:0]       rk_top;
  logic [127:0]       rk_cur;
  logic [127:0]       round_out;

  assign accept  = (st == IDLE) && in_ready_q && bus.in_valid;
  assign size_ok = (bus.size == SZ_128) || (bus.size == SZ_192);
  assign nr_sel  = (bus.size == SZ_192) ? NR_192 : NR_128;

  // rk[Nr] is taken straight from the bus for the initial AddRoundKey.
  assign rk_top = (bus.size == SZ_192) ?
                  bus.key_sched[KSCHED_W-1-128*int'(NR_192) -: 128] :
                  bus.key_sched[KSCHED_W-1-128*int'(NR_128) -: 128];

  // Pick the latched round key addressed by the round counter.
  always_comb begin
    rk_cur = '0;
    for (int i = 0; i < NK_MAX - 1; i++) begin
      if (rnd == 4'(i)) rk_cur = ks_q[LATCH_W-1-128*i -: 128];
    end
  end

  aes_inv_round u_round (
    .state_in  (state_q),
    .rk        (rk_cur),
    .last      (rnd == 4'd0),
    .state_out (round_out)
  );

  // Schedule capture; the source may change key_sched after accept.
  always_ff @(posedge clk) begin
    if (accept) ks_q <= bus.key_sched[KSCHED_W-1 -: LATCH_W];
  end

  // Control FSM, round counter, state register and output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      rnd         <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (size_ok) begin
              state_q <= bus.in ^ rk_top;
              rnd     <= nr_sel - 4'd1;
              st      <= RUN;
            end else begin
              out_q <= '0;
              err_q <= 1'b1;
              st    <= DONE;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (rnd == 4'd0) begin
            out_q       <= round_out;
            out_valid_q <= 1'b1;
            err_q       <= 1'b0;
            st          <= DONE;
          end else begin
            state_q <= round_out;
            rnd     <= rnd - 4'd1;
          end
        end
        DONE: begin
          // Entered with out_valid low only from the unsupported-size path,
          // which raises out_valid one cycle after accept.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            st          <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
//   Self-checking bench for aes_inv_cipher_iter: FIPS-197 known answers,
//   backpressure, unsupported size, reset mid-block and random round trips
//   through a behavioural AES encryptor built from GF(2^8) arithmetic.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;
  import aes_pkg::*;

  typedef struct {
    string        name;
    logic [127:0] ct;
    logic [191:0] key;
    logic [1:0]   sz;
    logic [127:0] exp_pt;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   hold_ready = 1'b0;
  int   vec_count  = 0;
  int   miscompares = 0;
  logic [7:0] sbox_t [256];

  aes_inv_cipher_iter_if bus ();

  aes_inv_cipher_iter #(.NK_MAX(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock; outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [KSCHED_W-1:0] rand_ks();
    logic [KSCHED_W-1:0] k;
    for (int i = 0; i < KSCHED_W / 32; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  function automatic int nr_of(input logic [1:0] sz);
    return (sz == SZ_192) ? 12 : 10;
  endfunction

  // FIPS-197 key expansion; slots beyond Nr keep the filler bits.
  // A 128-bit key occupies key[191:64].
  function automatic logic [KSCHED_W-1:0] expand_key(input logic [191:0] key,
                                                     input logic [1:0] sz,
                                                     input logic [KSCHED_W-1:0] filler);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    logic [KSCHED_W-1:0] ks = filler;
    int nk = (sz == SZ_192) ? 6 : 4;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[191-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      ks[128*(13-r)-1 -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Forward cipher on a byte array; state byte r+4c is row r, column c.
  function automatic logic [127:0] enc_block(input logic [127:0] pt,
                                             input logic [KSCHED_W-1:0] ks,
                                             input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk;
    logic [127:0] res;
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ ks[KSCHED_W-1-8*b -: 8];
    for (int round = 1; round <= nr; round++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_t[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        if (round != nr) begin
          s[4*c]   = gf_mul(t[4*c], 8'h02) ^ gf_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 8'h02) ^ gf_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 8'h02) ^ gf_mul(t[4*c+3], 8'h03);
          s[4*c+3] = gf_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*c];
        end
      end
      rk = ks[128*(13-round)-1 -: 128];
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ rk[127-8*b -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // Single comparison: counts it and reports a miscompare.
  task automatic checkField(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one block (called at a falling edge), wait for acceptance and
  // return at the falling edge right after the accepting edge. Inputs are
  // then scrambled since the core must not depend on them after accept.
  task automatic applyStimulus(input logic [127:0] ct, input logic [KSCHED_W-1:0] ks,
                               input logic [1:0] sz);
    int w = 0;
    bus.in        = ct;
    bus.key_sched = ks;
    bus.size      = sz;
    bus.in_valid  = 1'b1;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkField("accept wait", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in        = rand128();
    bus.key_sched = rand_ks();
    bus.size      = 2'(($urandom() % 2) + 2);
  endtask

  // Count cycles until out_valid, compare result, then optionally complete
  // the output handshake and confirm the core went back to idle.
  task automatic checkOutput(input string name, input logic [127:0] exp_out, input logic exp_err,
                             input int exp_lat, input bit complete);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkField({name, " latency"}, 128'(k), 128'(exp_lat));
    checkField({name, " out"}, bus.out, exp_out);
    checkField({name, " err"}, 128'(bus.err), 128'(exp_err));
    if (complete) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkField({name, " handshake"}, 128'({bus.out_valid, bus.in_ready, bus.err}), 128'(3'b010));
      checkField({name, " out hold"}, bus.out, exp_out);
      bus.out_ready = hold_ready;
    end
  endtask

  // Main sequence: reset, vector table, corner-case sequences, random round trips.
  initial begin
    vec_t vecs [7];
    logic [KSCHED_W-1:0] ks;
    logic [127:0] pt, ct;
    logic [191:0] key;
    logic [1:0]   sz;
    int           ov_count;

    vecs[0] = '{"C1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                {128'h000102030405060708090a0b0c0d0e0f, 64'h0}, SZ_128,
                128'h00112233445566778899aabbccddeeff, 1'b0, 10};
    vecs[1] = '{"C2", 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                192'h000102030405060708090a0b0c0d0e0f1011121314151617, SZ_192,
                128'h00112233445566778899aabbccddeeff, 1'b0, 12};
    vecs[2] = '{"B", 128'h3925841d02dc09fbdc118597196a0b32,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 64'h0}, SZ_128,
                128'h3243f6a8885a308d313198a2e0370734, 1'b0, 10};
    vecs[3] = '{"size10", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 192'h0, 2'b10,
                128'h0, 1'b1, 1};
    vecs[4] = '{"C1 after err", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                {128'h000102030405060708090a0b0c0d0e0f, 64'h0}, SZ_128,
                128'h00112233445566778899aabbccddeeff, 1'b0, 10};
    vecs[5] = '{"size11", 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 192'h0, 2'b11,
                128'h0, 1'b1, 1};
    vecs[6] = '{"C2 after err", 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                192'h000102030405060708090a0b0c0d0e0f1011121314151617, SZ_192,
                128'h00112233445566778899aabbccddeeff, 1'b0, 12};

    build_sbox();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in        = '0;
    bus.key_sched = '0;
    bus.size      = SZ_128;

    repeat (3) @(negedge clk);
    checkField("reset state", 128'({bus.in_ready, bus.out_valid, bus.err}), 128'(3'b000));
    checkField("reset out", bus.out, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkField("in_ready after reset", 128'(bus.in_ready), 128'(1));

    for (int i = 0; i < 7; i++) begin
      ks = vecs[i].exp_err ? rand_ks() : expand_key(vecs[i].key, vecs[i].sz, rand_ks());
      applyStimulus(vecs[i].ct, ks, vecs[i].sz);
      checkOutput(vecs[i].name, vecs[i].exp_pt, vecs[i].exp_err, vecs[i].exp_lat, 1'b1);
    end

    $display("[TB] backpressure sequence");
    applyStimulus(vecs[0].ct, expand_key(vecs[0].key, SZ_128, rand_ks()), SZ_128);
    checkOutput("bp C1", vecs[0].exp_pt, 1'b0, 10, 1'b0);
    bus.in        = vecs[1].ct;
    bus.key_sched = expand_key(vecs[1].key, SZ_192, rand_ks());
    bus.size      = SZ_192;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkField("bp hold", {bus.out_valid, bus.in_ready, bus.err, bus.out[124:0]},
                 {3'b100, vecs[0].exp_pt[124:0]});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkField("bp release", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkField("bp next accept", 128'(bus.in_ready), 128'(0));
    bus.in_valid = 1'b0;
    checkOutput("bp C2", vecs[1].exp_pt, 1'b0, 12, 1'b1);

    $display("[TB] reset mid-operation sequence");
    applyStimulus(vecs[0].ct, expand_key(vecs[0].key, SZ_128, rand_ks()), SZ_128);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkField("mid reset state", 128'({bus.in_ready, bus.out_valid, bus.err}), 128'(3'b000));
    @(negedge clk);
    checkField("mid reset in_ready", 128'(bus.in_ready), 128'(1));
    ov_count = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid === 1'b1) ov_count++;
      @(negedge clk);
    end
    checkField("abandoned block out_valid", 128'(ov_count), 128'(0));
    applyStimulus(vecs[0].ct, expand_key(vecs[0].key, SZ_128, rand_ks()), SZ_128);
    checkOutput("fresh C1", vecs[0].exp_pt, 1'b0, 10, 1'b1);

    $display("[TB] random round trips");
    for (int n = 0; n < 1000 && miscompares < 20; n++) begin
      sz  = 2'($urandom_range(0, 1));
      pt  = rand128();
      key = {rand128(), $urandom(), $urandom()};
      ks  = expand_key(key, sz, rand_ks());
      ct  = enc_block(pt, ks, nr_of(sz));
      hold_ready    = ($urandom_range(0, 3) == 0);
      bus.out_ready = hold_ready;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(ct, ks, sz);
      checkOutput("random", pt, 1'b0, nr_of(sz), 1'b1);
    end
    hold_ready    = 1'b0;
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
